shift_counter: RTL and testbench

Parametrised N-bit shift-register counter with run-time selection between ring (one-hot) and Johnson (twisted-ring) sequencing. It supports direction control, count enable, parallel load, illegal-state self-correction with an error pulse, a terminal-count flag and a decoded position output. It is the general-purpose sequencer for phase/slot generation, replacing fixed-width, fixed-direction ring counters.

---
 rtl/shift_counter.sv | 53 +++++
 tb/tb_shift_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/shift_counter.sv
// shift_counter: N-bit ring/Johnson shift-register counter with direction, load,
// illegal-state self-correction, terminal-count flag and decoded position.
module shift_counter #(
  parameter int N = 4,
  parameter logic [N-1:0] INIT = {{(N-1){1'b0}}, 1'b1},
  localparam int POS_W = $clog2(2*N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [N-1:0]     load_val,
  output logic [N-1:0]     out,
  output logic             tc,
  output logic             err,
  output logic [POS_W-1:0] pos
);
  localparam int CW = POS_W + 1;
  logic [N-1:0] out_q, out_d, inv, step;
  logic err_q, err_d, ring_ok, john_ok, legal;
  logic [CW-1:0] ones;
  logic [POS_W-1:0] ridx, jpos;
  assign inv = ~out_q;
  assign ring_ok = (out_q != '0) && ((out_q & (out_q - N'(1))) == '0);
  // Johnson-legal means ones packed against the LSB, or zeros packed against the LSB
  assign john_ok = ((out_q & (out_q + N'(1))) == '0) || ((inv & (inv + N'(1))) == '0);
  assign legal = mode ? john_ok : ring_ok;
  always_comb begin
    ones = '0;
    ridx = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + CW'(out_q[i]);
      ridx = out_q[i] ? POS_W'(i) : ridx;
    end
  end
  assign jpos = (out_q[0] || out_q == '0) ? POS_W'(ones) : POS_W'(CW'(2*N) - ones);
  assign pos = !legal ? '0 : mode ? jpos : ridx;
  assign tc = en && legal && (dir ? out_q == N'(1) : out_q == {1'b1, {(N-1){1'b0}}});
  assign step = mode ? (dir ? {~out_q[0], out_q[N-1:1]} : {out_q[N-2:0], ~out_q[N-1]})
                     : (dir ? {out_q[0], out_q[N-1:1]} : {out_q[N-2:0], out_q[N-1]});
  always_comb begin
    out_d = rst ? INIT : load ? load_val : !en ? out_q : legal ? step : (mode ? '0 : INIT);
    err_d = !rst && !load && en && !legal;
  end
  always_ff @(posedge clk) begin
    out_q <= out_d;
    err_q <= err_d;
  end
  assign out = out_q;
  assign err = err_q;
endmodule

// File: tb/tb_shift_counter.sv
// tb_shift_counter: scoreboard bench driving N=4, N=2 and N=8 counters from
// shared stimulus, checked against sequence-table reference models.
module tb_shift_counter;
  localparam int NS [3] = '{4, 2, 8};
  logic clk = 0, rst = 1, en = 0, dir = 0, mode = 0, load = 0;
  logic [7:0] load_val = '0;
  logic [3:0] o4;
  logic [1:0] o2;
  logic [7:0] o8;
  logic [2:0] p4;
  logic [1:0] p2;
  logic [3:0] p8;
  logic t4, t2, t8, e4, e2, e8;
  logic [7:0] d_out [3];
  logic [3:0] d_pos [3];
  logic d_tc [3], d_err [3];

  shift_counter #(.N(4)) u4 (.clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val[3:0]), .out(o4), .tc(t4), .err(e4), .pos(p4));
  shift_counter #(.N(2)) u2 (.clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val[1:0]), .out(o2), .tc(t2), .err(e2), .pos(p2));
  shift_counter #(.N(8)) u8 (.clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .out(o8), .tc(t8), .err(e8), .pos(p8));

  assign d_out[0] = {4'b0, o4};
  assign d_out[1] = {6'b0, o2};
  assign d_out[2] = o8;
  assign d_pos[0] = {1'b0, p4};
  assign d_pos[1] = {2'b0, p2};
  assign d_pos[2] = p8;
  assign d_tc[0] = t4;
  assign d_tc[1] = t2;
  assign d_tc[2] = t8;
  assign d_err[0] = e4;
  assign d_err[1] = e2;
  assign d_err[2] = e8;

  always #5 clk = ~clk;

  typedef struct packed {
    logic chk;
    logic [2:0] tc;
    logic [2:0][3:0] pos;
    logic [2:0][7:0] nout;
    logic [2:0] err;
  } exp_t;

  exp_t q [$];
  logic [7:0] mdl [3] = '{8'd1, 8'd1, 8'd1};
  bit started = 0;
  int n_cmp = 0, n_bad = 0;

  // k-th state of the sequence, counting left steps from the wrap point
  function automatic logic [7:0] seq(int n, bit jm, int k);
    int v;
    if (!jm) v = 1 << k;
    else if (k <= n) v = (1 << k) - 1;
    else v = ((1 << n) - 1) ^ ((1 << (k - n)) - 1);
    return 8'(v);
  endfunction

  function automatic int find(int n, bit jm, logic [7:0] v);
    for (int k = 0; k < (jm ? 2*n : n); k++)
      if (seq(n, jm, k) == v) return k;
    return -1;
  endfunction

  task automatic chk(string nm, int i, logic [7:0] a, logic [7:0] ex);
    n_cmp++;
    if (a !== ex) begin
      n_bad++;
      $display("FAIL %s N=%0d: got %h expected %h at %0t", nm, NS[i], a, ex, $time);
    end
  endtask

  task automatic step(input bit r, input bit l, input logic [7:0] lv, input bit e, input bit d, input bit m);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; load_val = lv; en = e; dir = d; mode = m;
    x = '0;
    x.chk = started;
    for (int i = 0; i < 3; i++) begin
      int n = NS[i];
      int len = m ? 2*n : n;
      int k = find(n, m, mdl[i]);
      bit lg = k >= 0;
      x.tc[i] = e && lg && (d ? mdl[i] == 8'd1 : mdl[i] == 8'(1 << (n-1)));
      x.pos[i] = lg ? 4'(k) : 4'd0;
      x.err[i] = !r && !l && e && !lg;
      mdl[i] = r ? 8'd1 : l ? (lv & 8'((1 << n) - 1)) : !e ? mdl[i]
             : lg ? seq(n, m, (k + (d ? len - 1 : 1)) % len) : (m ? 8'd0 : 8'd1);
      x.nout[i] = mdl[i];
    end
    started = 1;
    q.push_back(x);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 3; i++)
          if (e.chk) begin
            chk("tc", i, {7'b0, d_tc[i]}, {7'b0, e.tc[i]});
            chk("pos", i, {4'b0, d_pos[i]}, {4'b0, e.pos[i]});
          end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
          chk("out", i, d_out[i], e.nout[i]);
          chk("err", i, {7'b0, d_err[i]}, {7'b0, e.err[i]});
        end
      end
    end
  end

  initial begin
    bit d, m;
    step(1, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1, 0, 0);
    step(0, 1, 8'h00, 0, 0, 1);
    repeat (8) step(0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1, 1, 0);
    repeat (4) step(0, 0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 1, 1, 0);
    step(0, 1, 8'h06, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 8'h05, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 8'h00, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 1, 8'h0a, 1, 0, 0);
    step(0, 1, 8'h04, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 8'h07, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (16) step(0, 0, 0, 1, 0, 0);
    repeat (16) step(0, 0, 0, 1, 1, 0);
    step(0, 1, 8'h00, 0, 0, 1);
    repeat (16) step(0, 0, 0, 1, 0, 1);
    repeat (16) step(0, 0, 0, 1, 1, 1);
    d = 0;
    m = 0;
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 99) < 10) d = ~d;
      if ($urandom_range(0, 99) < 5) m = ~m;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8, 8'($urandom),
           $urandom_range(0, 99) < 80, d, m);
    end
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
